tmds_link_sequencer: RTL

//   Bring-up and run-time controller for the three TMDS serializer lanes in the pixel clock domain.

---
 rtl/hdmi_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/tmds_link_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions: symbol type, the four DVI control symbols and link FSM states.
package hdmi_pkg;

  typedef logic [9:0] tmds_sym_t;

  // Control symbols indexed by {vsync,hsync}
  localparam tmds_sym_t CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    RESET_HOLD = 2'd1,
    FLUSH      = 2'd2,
    RUN        = 2'd3
  } link_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for single-bit or multi-bit quasi-static CDC inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tmds_link_sequencer.sv
// TMDS lane bring-up controller: lock qualification, serializer reset sequencing,
// control-symbol flush, then hand-off to the encoders; aborts to a safe state on lock loss.
module tmds_link_sequencer
  import hdmi_pkg::*;
#(
  parameter int LOCK_FILTER  = 8,
  parameter int RESET_CYCLES = 16,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic        pix_clk,
  input  logic        reset_n,
  input  logic        mmcm_locked,
  input  logic        enable,
  input  logic [29:0] tmds_in,
  output logic [29:0] tmds_out,
  output logic        serdes_reset,
  output logic        video_en,
  output logic [1:0]  link_state,
  output logic [7:0]  lock_loss_cnt
);

  localparam int CNT_MAX = max3(LOCK_FILTER, RESET_CYCLES, FLUSH_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LF_TC = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] RC_TC = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] FC_TC = CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [29:0] CTRL_LANES = {3{CTRL_00}};

  logic             w_locked_s;
  logic             w_qual;
  link_state_t      w_nxt_state;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_loss;

  link_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [29:0]      r_tmds;
  logic             r_serdes_reset;
  logic             r_video_en;
  logic [7:0]       r_loss_cnt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (pix_clk),
    .i_rst_n (reset_n),
    .i_d     (mmcm_locked),
    .o_q     (w_locked_s)
  );

  assign w_qual = w_locked_s && enable;

  always_comb begin
    w_nxt_state = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_loss      = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        // The terminal count only counts if this cycle also qualifies
        if (!w_qual)             w_cnt_clr   = 1'b1;
        else if (r_cnt == LF_TC) w_nxt_state = RESET_HOLD;
        else                     w_cnt_inc   = 1'b1;
      end
      RESET_HOLD: begin
        if (r_cnt == RC_TC) w_nxt_state = FLUSH;
        else                w_cnt_inc   = 1'b1;
      end
      FLUSH: begin
        if (r_cnt == FC_TC) w_nxt_state = RUN;
        else                w_cnt_inc   = 1'b1;
      end
      RUN:     w_nxt_state = RUN;
      default: w_nxt_state = WAIT_LOCK;
    endcase
    // Abort has priority over any terminal-count transition above
    if (r_state != WAIT_LOCK) begin
      if (!w_locked_s) begin
        w_nxt_state = WAIT_LOCK;
        w_loss      = (r_state == FLUSH) || (r_state == RUN);
      end else if (!enable) begin
        w_nxt_state = WAIT_LOCK;
      end
    end
  end

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= WAIT_LOCK;
      r_cnt          <= '0;
      r_tmds         <= CTRL_LANES;
      r_serdes_reset <= 1'b1;
      r_video_en     <= 1'b0;
      r_loss_cnt     <= 8'd0;
    end else begin
      r_state <= w_nxt_state;
      if ((w_nxt_state != r_state) || w_cnt_clr) r_cnt <= '0;
      else if (w_cnt_inc)                         r_cnt <= r_cnt + 1'b1;

      if (w_loss && (r_loss_cnt != 8'hFF)) r_loss_cnt <= r_loss_cnt + 8'd1;

      // Outputs follow the next state so they line up with link_state
      r_serdes_reset <= (w_nxt_state == WAIT_LOCK) || (w_nxt_state == RESET_HOLD);
      r_video_en     <= (w_nxt_state == RUN);
      r_tmds         <= (w_nxt_state == RUN) ? tmds_in : CTRL_LANES;
    end
  end

  assign tmds_out      = r_tmds;
  assign serdes_reset  = r_serdes_reset;
  assign video_en      = r_video_en;
  assign link_state    = r_state;
  assign lock_loss_cnt = r_loss_cnt;

endmodule
